wr_ptr_full_ctrl: RTL and testbench

Write-side pointer and full-flag controller of the asynchronous FIFO, clocked entirely in the wr_clk domain. It accepts write requests, advances a binary write pointer, and publishes a registered Gray-coded copy of that pointer for synchronization into the read domain. It compares the Gray read pointer, already synchronized into wr_clk, against its own pointer to produce full, almost-full, occupancy and overflow status. It drives the write port of the FIFO memory.

---
 rtl/wr_ptr_full_ctrl_pkg.sv | 54 +++++
 rtl/wr_ptr_full_ctrl_gray2bin_dec.sv | 17 +
 rtl/wr_ptr_full_ctrl.sv | 77 +++++++
 tb/tb_wr_ptr_full_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_ptr_full_ctrl_pkg.sv
// Shared FIFO package: default sizing and Gray/binary conversion helpers.
// The read-side empty controller imports the same package so both domains
// agree on pointer width and Gray encoding.
package wr_ptr_full_ctrl_pkg;

    // Default address width; FIFO depth is 2**ADD_WIDTH.
    localparam int DEFAULT_ADD_WIDTH = 3;

    // Pointers carry one extra wrap bit beyond the address.
    localparam int PTR_WIDTH = DEFAULT_ADD_WIDTH + 1;

    // Widest pointer the helper functions handle.
    localparam int MAX_PTR_WIDTH = 32;

    typedef logic [MAX_PTR_WIDTH-1:0] ptr_word_t;

    // Pointer width for a given address width.
    function automatic int ptr_width(input int add_width);
        return add_width + 1;
    endfunction

    // Mask keeping only the low 'width' bits of a pointer word.
    function automatic ptr_word_t width_mask(input int width);
        ptr_word_t m;
        m = '0;
        for (int i = 0; i < MAX_PTR_WIDTH; i++) begin
            if (i < width) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Binary to Gray over the low 'width' bits.
    function automatic ptr_word_t bin2gray(input ptr_word_t bin, input int width);
        ptr_word_t b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary over the low 'width' bits: each binary bit is the XOR
    // of all Gray bits at or above it.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray, input int width);
        ptr_word_t g;
        ptr_word_t b;
        g = gray & width_mask(width);
        b = g;
        for (int i = 1; i < MAX_PTR_WIDTH; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wr_ptr_full_ctrl_gray2bin_dec.sv
// Combinational XOR-prefix decoder turning the synchronized Gray read
// pointer back into binary so the writer can compute occupancy.
module gray2bin_dec
    import wr_ptr_full_ctrl_pkg::*;
#(
    parameter int WIDTH = PTR_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Decode through the shared package helper so both domains match.
    always_comb begin
        bin = WIDTH'(gray2bin(MAX_PTR_WIDTH'(gray), WIDTH));
    end

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// Write-side pointer and full-flag controller of the asynchronous FIFO.
// Everything here runs on wr_clk; the read pointer arrives already
// synchronized, and the Gray write pointer leaves registered so only one
// bit changes per clock on its way to the read domain.
module wr_ptr_full_ctrl
    import wr_ptr_full_ctrl_pkg::*;
#(
    parameter int ADD_WIDTH = DEFAULT_ADD_WIDTH,
    parameter int AFULL_LVL = 6
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_en,
    input  logic [ADD_WIDTH:0]   rd_ptr_gray_sync,
    output logic                 wr_accept,
    output logic [ADD_WIDTH-1:0] wr_addr,
    output logic [ADD_WIDTH:0]   wr_ptr_gray,
    output logic                 wr_full,
    output logic                 wr_almost_full,
    output logic [ADD_WIDTH:0]   wr_level,
    output logic                 wr_overflow
);

    localparam int PW = ADD_WIDTH + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_pattern;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          almost_full_next;

    gray2bin_dec #(
        .WIDTH(PW)
    ) u_rd_dec (
        .gray(rd_ptr_gray_sync),
        .bin (rbin)
    );

    assign wr_addr = wbin[ADD_WIDTH-1:0];

    // Next-pointer, full and occupancy computation for the coming edge.
    always_comb begin
        wr_accept        = wr_en & ~wr_full & wr_rst;
        wbin_next        = wbin + {{(PW-1){1'b0}}, wr_accept};
        wgray_next       = PW'(bin2gray(MAX_PTR_WIDTH'(wbin_next), PW));
        full_pattern     = {~rd_ptr_gray_sync[PW-1:PW-2], rd_ptr_gray_sync[PW-3:0]};
        full_next        = (wgray_next == full_pattern);
        level_next       = wbin_next - rbin;
        almost_full_next = (level_next >= PW'(AFULL_LVL));
    end

    // Pointer and status registers; a write while full leaves pointers
    // untouched and latches the sticky overflow flag.
    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            wbin           <= '0;
            wr_ptr_gray    <= '0;
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            wr_level       <= '0;
            wr_overflow    <= 1'b0;
        end else begin
            wbin           <= wbin_next;
            wr_ptr_gray    <= wgray_next;
            wr_full        <= full_next;
            wr_almost_full <= almost_full_next;
            wr_level       <= level_next;
            if (wr_en && wr_full) begin
                wr_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wr_ptr_full_ctrl.sv
// Self-checking bench for wr_ptr_full_ctrl: an occupancy-count model
// (writes accepted minus reads observed) predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_wr_ptr_full_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic          wr_clk = 1'b0;
    logic          wr_rst = 1'b1;
    logic          wr_en  = 1'b0;
    logic [AW:0]   rd_ptr_gray_sync;
    logic          wr_accept;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   wr_ptr_gray;
    logic          wr_full;
    logic          wr_almost_full;
    logic [AW:0]   wr_level;
    logic          wr_overflow;

    int rd_count = 0;
    int errors   = 0;
    int checks   = 0;

    int m_wcnt   = 0;
    int m_level  = 0;
    bit m_full   = 1'b0;
    bit m_afull  = 1'b0;
    bit m_ovf    = 1'b0;
    int m_resets = 0;

    logic [AW:0] fill_tab [8];

    wr_ptr_full_ctrl #(
        .ADD_WIDTH(AW),
        .AFULL_LVL(AFULL)
    ) dut (
        .wr_clk          (wr_clk),
        .wr_rst          (wr_rst),
        .wr_en           (wr_en),
        .rd_ptr_gray_sync(rd_ptr_gray_sync),
        .wr_accept       (wr_accept),
        .wr_addr         (wr_addr),
        .wr_ptr_gray     (wr_ptr_gray),
        .wr_full         (wr_full),
        .wr_almost_full  (wr_almost_full),
        .wr_level        (wr_level),
        .wr_overflow     (wr_overflow)
    );

    always #5 wr_clk = ~wr_clk;

    function automatic logic [AW:0] gray_of(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    assign rd_ptr_gray_sync = gray_of(rd_count);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en    = 1'b0;
        wr_rst   = 1'b0;
        rd_count = 0;
        step();
        step();
        wr_rst = 1'b1;
    endtask

    // Behavioural model: occupancy is writes accepted minus reads seen.
    initial begin
        bit acc;
        forever begin
            @(posedge wr_clk or negedge wr_rst);
            if (!wr_rst) begin
                m_wcnt  = 0;
                m_level = 0;
                m_full  = 1'b0;
                m_afull = 1'b0;
                m_ovf   = 1'b0;
                m_resets++;
            end else begin
                acc = wr_en && !m_full;
                if (wr_en && m_full) m_ovf = 1'b1;
                if (acc) m_wcnt++;
                m_level = m_wcnt - rd_count;
                m_full  = (m_level == DEPTH);
                m_afull = (m_level >= AFULL);
            end
        end
    end

    // Compare process: every mid-cycle out of reset, DUT against model.
    initial begin
        logic [AW:0] prev_gray;
        bit          have_prev;
        int          seen_resets;
        have_prev   = 1'b0;
        seen_resets = 0;
        prev_gray   = '0;
        forever begin
            @(negedge wr_clk);
            if (wr_rst) begin
                check("accept",    32'(wr_accept),      32'(wr_en && !m_full));
                check("addr",      32'(wr_addr),        32'(m_wcnt % DEPTH));
                check("gray",      32'(wr_ptr_gray),    32'(gray_of(m_wcnt)));
                check("full",      32'(wr_full),        32'(m_full));
                check("afull",     32'(wr_almost_full), 32'(m_afull));
                check("level",     32'(wr_level),       32'(m_level));
                check("overflow",  32'(wr_overflow),    32'(m_ovf));
                if (have_prev && seen_resets == m_resets) begin
                    check("gray_step", 32'($countones(prev_gray ^ wr_ptr_gray) <= 1), 32'(1));
                end
                prev_gray   = wr_ptr_gray;
                have_prev   = 1'b1;
                seen_resets = m_resets;
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        fill_tab[0] = 4'b0001; fill_tab[1] = 4'b0011;
        fill_tab[2] = 4'b0010; fill_tab[3] = 4'b0110;
        fill_tab[4] = 4'b0111; fill_tab[5] = 4'b0101;
        fill_tab[6] = 4'b0100; fill_tab[7] = 4'b1100;

        wr_en = 1'b1;
        #3 wr_rst = 1'b0;
        #1;
        check("rst_accept",   32'(wr_accept),      32'(0));
        check("rst_gray",     32'(wr_ptr_gray),    32'(0));
        check("rst_addr",     32'(wr_addr),        32'(0));
        check("rst_full",     32'(wr_full),        32'(0));
        check("rst_level",    32'(wr_level),       32'(0));
        check("rst_overflow", 32'(wr_overflow),    32'(0));
        do_reset();

        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("fill_gray", 32'(wr_ptr_gray), 32'(fill_tab[i]));
        end
        check("fill_full",  32'(wr_full),        32'(1));
        check("fill_level", 32'(wr_level),       32'(8));
        check("fill_afull", 32'(wr_almost_full), 32'(1));

        check("ovf_accept", 32'(wr_accept), 32'(0));
        step();
        step();
        check("ovf_addr",  32'(wr_addr),     32'(0));
        check("ovf_gray",  32'(wr_ptr_gray), 32'(4'b1100));
        check("ovf_flag",  32'(wr_overflow), 32'(1));
        wr_en = 1'b0;
        step();
        check("ovf_sticky", 32'(wr_overflow), 32'(1));

        rd_count = 1;
        step();
        check("rel_full",  32'(wr_full),        32'(0));
        check("rel_level", 32'(wr_level),       32'(7));
        check("rel_afull", 32'(wr_almost_full), 32'(1));
        wr_en = 1'b1;
        #1;
        check("rel_accept", 32'(wr_accept), 32'(1));
        check("rel_addr",   32'(wr_addr),   32'(0));
        step();
        wr_en = 1'b0;
        check("rel_addr_after", 32'(wr_addr), 32'(1));

        rd_count = 9;
        step();
        check("af_empty", 32'(wr_level), 32'(0));
        wr_en = 1'b1;
        repeat (5) step();
        wr_en = 1'b0;
        check("af_five_flag",  32'(wr_almost_full), 32'(0));
        check("af_five_level", 32'(wr_level),       32'(5));
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        check("af_six_flag",  32'(wr_almost_full), 32'(1));
        check("af_six_level", 32'(wr_level),       32'(6));

        do_reset();
        wr_en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check("wrap_full", 32'(wr_full), 32'(0));
            if (i == 15) check("wrap_gray15", 32'(wr_ptr_gray), 32'(4'b1000));
            if (i == 16) check("wrap_gray16", 32'(wr_ptr_gray), 32'(4'b0000));
            if (i >= 2) rd_count = i - 2;
        end
        wr_en = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            int phase;
            phase = (n / 250) % 2;
            wr_en = ($urandom_range(0, 3) < ((phase == 1) ? 1 : 3));
            if (rd_count < m_wcnt && $urandom_range(0, 2) < ((phase == 1) ? 2 : 1)) begin
                rd_count++;
            end
            step();
        end

        wr_en    = 1'b0;
        rd_count = m_wcnt;
        step();
        wr_en = 1'b1;
        repeat (5) step();
        check("mid_level", 32'(wr_level), 32'(5));
        #1 wr_rst = 1'b0;
        rd_count = 0;
        #1;
        check("mid_accept",   32'(wr_accept),      32'(0));
        check("mid_addr",     32'(wr_addr),        32'(0));
        check("mid_gray",     32'(wr_ptr_gray),    32'(0));
        check("mid_level0",   32'(wr_level),       32'(0));
        check("mid_afull",    32'(wr_almost_full), 32'(0));
        check("mid_overflow", 32'(wr_overflow),    32'(0));
        wr_rst = 1'b1;
        #1;
        check("post_accept", 32'(wr_accept), 32'(1));
        check("post_addr",   32'(wr_addr),   32'(0));
        step();
        wr_en = 1'b0;
        check("post_addr1",  32'(wr_addr),  32'(1));
        check("post_level1", 32'(wr_level), 32'(1));
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
